// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the M-extension sequencer: op codes, FSM states,
// width constants and small op-classification helpers.
package m_ext_defs;

    localparam int MDU_XLEN       = 32;
    localparam int MDU_DIV_CYCLES = MDU_XLEN;

    typedef enum logic [3:0] {
        ALU_M_NONE   = 4'd0,
        ALU_M_MUL    = 4'd1,
        ALU_M_MULH   = 4'd2,
        ALU_M_MULHSU = 4'd3,
        ALU_M_MULHU  = 4'd4,
        ALU_M_DIV    = 4'd5,
        ALU_M_DIVU   = 4'd6,
        ALU_M_REM    = 4'd7,
        ALU_M_REMU   = 4'd8
    } type_alu_m_ops_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } type_mdu_state_e;

    // Codes 9-15 fall outside both ranges and therefore behave like NONE.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op >= ALU_M_MUL) && (op <= ALU_M_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op >= ALU_M_DIV) && (op <= ALU_M_REMU);
    endfunction

    function automatic logic is_m_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

    function automatic logic is_signed_div(input logic [3:0] op);
        return (op == ALU_M_DIV) || (op == ALU_M_REM);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == ALU_M_REM) || (op == ALU_M_REMU);
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle for
// XLEN cycles after start. done_o is high during the final iteration, so the
// quotient/remainder outputs are complete from the following cycle on.
module mdu_div_iter
    import m_ext_defs::*;
#(
    parameter int XLEN = MDU_DIV_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    // One extra bit so the counter can hold XLEN itself without wrapping.
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dsr_q;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    rem_diff;

    // Trial subtraction: a set top bit of the difference means the shifted
    // partial remainder was smaller than the divisor.
    always_comb begin
        rem_shift = {rem_q, quot_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dsr_q};
    end

    // Shift-subtract loop; the dividend shifts out of quot_q as quotient bits shift in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else if (kill_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q  <= CNT_W'(XLEN);
            quot_q <= dividend_i;
            rem_q  <= '0;
            dsr_q  <= divisor_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (!rem_diff[XLEN]) begin
                rem_q  <= rem_diff[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q  <= rem_shift[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign done_o      = (cnt_q == CNT_W'(1));
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_sched.sv
// M-extension sequencer: accepts an M-op from execute, runs the multiplier or
// the iterative divider, stalls the pipeline meanwhile and presents the result
// with a valid/ready handshake. A kill discards any in-flight work.
module mdu_sched
    import m_ext_defs::*;
#(
    parameter int XLEN    = MDU_XLEN,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic [3:0]      alu_m_ops_i,
    input  logic [XLEN-1:0] opr1_i,
    input  logic [XLEN-1:0] opr2_i,
    input  logic            kill_i,
    input  logic            result_ready_i,
    output logic            stall_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int MUL_CNT_W = $clog2(MUL_LAT + 1);

    type_mdu_state_e state_q, state_d;

    logic [3:0]           op_q;
    logic [XLEN-1:0]      opr1_q;
    logic [XLEN-1:0]      opr2_q;
    logic [XLEN-1:0]      result_q;
    logic                 q_neg_q;
    logic                 r_neg_q;
    logic                 div_norm_q;
    logic [MUL_CNT_W-1:0] mul_cnt_q;

    logic            op_valid;
    logic            accept;
    logic            in_mul;
    logic            in_div;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic            sgn_div;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_out;
    logic            mul_done;

    logic [3:0]        mul_op;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic              a_sgn;
    logic              b_sgn;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_val;

    // Accept decode plus special-case divide detection and operand magnitudes, all from the live inputs.
    always_comb begin
        op_valid  = is_m_op(alu_m_ops_i);
        accept    = (state_q == MDU_IDLE) && req_valid_i && op_valid && !kill_i;
        in_mul    = is_mul_op(alu_m_ops_i);
        in_div    = is_div_op(alu_m_ops_i);
        sgn_div   = is_signed_div(alu_m_ops_i);
        div_zero  = (opr2_i == '0);
        div_ovf   = sgn_div && (opr1_i == {1'b1, {(XLEN-1){1'b0}}}) && (opr2_i == '1);
        special   = in_div && (div_zero || div_ovf);
        if (div_zero)
            special_val = is_rem_op(alu_m_ops_i) ? opr1_i : '1;
        else
            special_val = is_rem_op(alu_m_ops_i) ? '0 : opr1_i;
        neg1      = sgn_div && opr1_i[XLEN-1];
        neg2      = sgn_div && opr2_i[XLEN-1];
        mag1      = neg1 ? -opr1_i : opr1_i;
        mag2      = neg2 ? -opr2_i : opr2_i;
        div_start = accept && in_div && !special;
    end

    // Multiplier: the sign-extension to 2*XLEN is equivalent to the (XLEN+1)-bit signed product, modulo 2^(2*XLEN).
    // Operands come from the ports in the accept cycle and from the latched copies afterwards.
    always_comb begin
        mul_op  = (state_q == MDU_IDLE) ? alu_m_ops_i : op_q;
        mul_a   = (state_q == MDU_IDLE) ? opr1_i : opr1_q;
        mul_b   = (state_q == MDU_IDLE) ? opr2_i : opr2_q;
        a_sgn   = (mul_op == ALU_M_MULH) || (mul_op == ALU_M_MULHSU);
        b_sgn   = (mul_op == ALU_M_MULH);
        a_ext   = {{XLEN{a_sgn && mul_a[XLEN-1]}}, mul_a};
        b_ext   = {{XLEN{b_sgn && mul_b[XLEN-1]}}, mul_b};
        prod    = a_ext * b_ext;
        mul_val = (mul_op == ALU_M_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    mdu_div_iter #(
        .XLEN        (XLEN)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .kill_i      (kill_i),
        .dividend_i  (mag1),
        .divisor_i   (mag2),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

    assign mul_done = (state_q == MDU_MUL) && (mul_cnt_q == MUL_CNT_W'(1));

    // Sign fix-up of the magnitude divide, applied while the result is presented.
    always_comb begin
        if (is_rem_op(op_q))
            div_out = r_neg_q ? -div_rem : div_rem;
        else
            div_out = q_neg_q ? -div_quot : div_quot;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= MDU_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a kill overrides both accept and completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    if (special)
                        state_d = MDU_DONE;
                    else if (in_mul)
                        state_d = (MUL_LAT == 1) ? MDU_DONE : MDU_MUL;
                    else
                        state_d = MDU_DIV;
                end
            end
            MDU_MUL:  if (mul_done) state_d = MDU_DONE;
            MDU_DIV:  if (div_done) state_d = MDU_DONE;
            MDU_DONE: if (result_ready_i) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (kill_i)
            state_d = MDU_IDLE;
    end

    // Operand/op capture at accept, multiplier countdown and result capture on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            opr1_q     <= '0;
            opr2_q     <= '0;
            result_q   <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_norm_q <= 1'b0;
            mul_cnt_q  <= '0;
        end else if (accept) begin
            op_q       <= alu_m_ops_i;
            opr1_q     <= opr1_i;
            opr2_q     <= opr2_i;
            q_neg_q    <= neg1 ^ neg2;
            r_neg_q    <= neg1;
            div_norm_q <= in_div && !special;
            mul_cnt_q  <= MUL_CNT_W'(MUL_LAT - 1);
            if (special)
                result_q <= special_val;
            else if (in_mul && (MUL_LAT == 1))
                result_q <= mul_val;
        end else if (state_q == MDU_MUL) begin
            mul_cnt_q <= mul_cnt_q - MUL_CNT_W'(1);
            if (mul_done)
                result_q <= mul_val;
        end
    end

    // Outputs; the result is only driven while presented in DONE.
    always_comb begin
        busy_o         = (state_q != MDU_IDLE);
        result_valid_o = (state_q == MDU_DONE);
        result_o       = '0;
        if (state_q == MDU_DONE)
            result_o = div_norm_q ? div_out : result_q;
        stall_o = !rst && req_valid_i && op_valid && (state_q != MDU_DONE) && !kill_i;
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: hand-computed results, latencies, stall
// behaviour, special divides, kill, result hold and asynchronous reset.
module tb_mdu_sched;
    import m_ext_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [3:0]  alu_m_ops_i;
    logic [31:0] opr1_i;
    logic [31:0] opr2_i;
    logic        kill_i;
    logic        result_ready_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic        busy_o;

    int checks = 0;
    int passes = 0;

    mdu_sched #(
        .XLEN           (32),
        .MUL_LAT        (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .alu_m_ops_i    (alu_m_ops_i),
        .opr1_i         (opr1_i),
        .opr2_i         (opr2_i),
        .kill_i         (kill_i),
        .result_ready_i (result_ready_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .busy_o         (busy_o)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one cycle and land just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an M-op request from the execute stage.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid_i = 1'b1;
        alu_m_ops_i = op;
        opr1_i      = a;
        opr2_i      = b;
    endtask

    // Issue one op from IDLE, measure latency and stall cycles, optionally hold
    // the result with ready low while the inputs wander, then consume it.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
        int cyc;
        int stall_cnt;
        cyc       = 0;
        stall_cnt = 0;
        result_ready_i = 1'b0;
        applyStimulus(op, a, b);
        #1;
        if (stall_o) stall_cnt++;
        while (cyc < 100) begin
            tick();
            cyc++;
            if (result_valid_o) break;
            if (stall_o) stall_cnt++;
        end
        checkOutput({tag, "_latency"}, cyc, lat);
        checkOutput({tag, "_result"}, result_o, exp);
        checkOutput({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        checkOutput({tag, "_stall_cycles"}, stall_cnt, lat);
        for (int i = 0; i < hold; i++) begin
            opr1_i = 32'h1234_5670 + i;
            opr2_i = 32'h0000_0003;
            tick();
            checkOutput({tag, "_hold_valid"}, {31'd0, result_valid_o}, 32'd1);
            checkOutput({tag, "_hold_result"}, result_o, exp);
            checkOutput({tag, "_hold_stall"}, {31'd0, stall_o}, 32'd0);
        end
        result_ready_i = 1'b1;
        req_valid_i    = 1'b0;
        alu_m_ops_i    = 4'd0;
        tick();
        result_ready_i = 1'b0;
        checkOutput({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
        checkOutput({tag, "_idle_valid"}, {31'd0, result_valid_o}, 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        rst            = 1'b1;
        kill_i         = 1'b0;
        result_ready_i = 1'b0;
        applyStimulus(ALU_M_MUL, 32'd7, 32'd3);
        #12;
        checkOutput("reset_result", result_o, 32'd0);
        checkOutput("reset_valid", {31'd0, result_valid_o}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
        req_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Undefined op codes are not M-ops.
        applyStimulus(4'd9, 32'd1, 32'd1);
        #1;
        checkOutput("code9_stall", {31'd0, stall_o}, 32'd0);
        tick();
        checkOutput("code9_busy", {31'd0, busy_o}, 32'd0);
        req_valid_i = 1'b0;

        runOp("mul_7x-3", ALU_M_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
        runOp("mulhu_ff", ALU_M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
        runOp("mulh_ff", ALU_M_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);
        runOp("mulhsu_ff", ALU_M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
        runOp("mul_ff", ALU_M_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2, 0);
        runOp("mulhu_big", ALU_M_MULHU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 2, 0);

        runOp("div_-7/2", ALU_M_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        runOp("rem_-7/2", ALU_M_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        runOp("rem_7/-2", ALU_M_REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0);
        runOp("remu_100/7", ALU_M_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

        runOp("divu_5/0", ALU_M_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        runOp("remu_5/0", ALU_M_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
        runOp("div_ovf", ALU_M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        runOp("rem_ovf", ALU_M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

        // Kill during the 10th divide iteration, then a MUL right after.
        applyStimulus(ALU_M_DIV, 32'hFFFF_FF9C, 32'd3);
        #1;
        checkOutput("kill_accept_stall", {31'd0, stall_o}, 32'd1);
        repeat (10) tick();
        checkOutput("kill_pre_busy", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        #1;
        checkOutput("kill_stall", {31'd0, stall_o}, 32'd0);
        tick();
        kill_i      = 1'b0;
        req_valid_i = 1'b0;
        #1;
        checkOutput("kill_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("kill_valid", {31'd0, result_valid_o}, 32'd0);
        runOp("mul_after_kill", ALU_M_MUL, 32'd6, 32'd7, 32'd42, 2, 0);

        // Result held with ready low; no re-accept of the wandering inputs.
        runOp("divu_100/7_hold", ALU_M_DIVU, 32'd100, 32'd7, 32'd14, 33, 3);

        // Asynchronous reset mid-divide, checked before any clock edge.
        applyStimulus(ALU_M_DIVU, 32'd1000, 32'd3);
        repeat (5) tick();
        checkOutput("rst_pre_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_result", result_o, 32'd0);
        checkOutput("rst_valid", {31'd0, result_valid_o}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
        req_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
